// File: rtl/seq_mag_cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator.
//   state_t : FSM encoding (S_IDLE = ready for a start, S_RUN = comparing)
//   clog2   : ceiling log2, used to size the digit counter and steps output
package seq_mag_cmp_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int tmp;
        result = 0;
        tmp    = value - 1;
        while (tmp > 0) begin
            result = result + 1;
            tmp    = tmp >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_mag_cmp_digit.sv
// cmp_digit: combinational unsigned compare of one DIGIT-bit slice.
//   a, b : digit operands
//   gt   : a > b
//   lt   : a < b
module cmp_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/seq_mag_cmp.sv
// seq_mag_cmp: multi-cycle magnitude comparator, MSB-first, DIGIT bits per clock.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : request, accepted only while ready = 1
//   is_signed, x, y : operands and mode, sampled with an accepted start
//   ready           : idle, next start is accepted
//   done            : one-cycle pulse, flags/steps valid from this cycle
//   xgy, xsy, xey   : x > y, x < y, x == y (one-hot after any completed compare)
//   steps           : digits examined in the last compare
//
// state  | meaning
// S_IDLE | waiting for start, ready = 1
// S_RUN  | comparing one digit per clock, ready = 0
module seq_mag_cmp
    import seq_mag_cmp_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int DIGIT      = 2,
    parameter  int EARLY_EXIT = 1,
    localparam int CW         = clog2(WIDTH / DIGIT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             ready,
    output logic             done,
    output logic             xgy,
    output logic             xsy,
    output logic             xey,
    output logic [CW-1:0]    steps
);

    localparam int NDIG = WIDTH / DIGIT;

    state_t           state_q;
    logic [WIDTH-1:0] xs_q;
    logic [WIDTH-1:0] ys_q;
    logic [CW-1:0]    cnt_q;
    logic             dif_q;
    logic             dif_gt_q;
    logic             ready_q;
    logic             done_q;
    logic             xgy_q;
    logic             xsy_q;
    logic             xey_q;
    logic [CW-1:0]    steps_q;

    logic             dig_gt;
    logic             dig_lt;
    logic             last;
    logic             fin_d;
    logic             fin_gt_d;
    logic             fin_lt_d;
    logic [CW-1:0]    fin_steps_d;
    logic [WIDTH-1:0] msb_mask;

    cmp_digit #(.DIGIT(DIGIT)) u_cmp_digit (
        .a  (xs_q[WIDTH-1 -: DIGIT]),
        .b  (ys_q[WIDTH-1 -: DIGIT]),
        .gt (dig_gt),
        .lt (dig_lt)
    );

    // Flipping both sign bits maps two's complement onto offset binary,
    // so the unsigned digit compare yields the signed order.
    assign msb_mask = WIDTH'(is_signed) << (WIDTH - 1);
    assign last     = (cnt_q == CW'(NDIG - 1));

    always_comb begin
        fin_d       = 1'b0;
        fin_gt_d    = 1'b0;
        fin_lt_d    = 1'b0;
        fin_steps_d = '0;
        if ((EARLY_EXIT != 0) && (dig_gt || dig_lt)) begin
            fin_d       = 1'b1;
            fin_gt_d    = dig_gt;
            fin_lt_d    = dig_lt;
            fin_steps_d = cnt_q + CW'(1);
        end else if (last) begin
            fin_d       = 1'b1;
            fin_steps_d = CW'(NDIG);
            // A difference recorded earlier outranks the final digit.
            if (dif_q) begin
                fin_gt_d = dif_gt_q;
                fin_lt_d = !dif_gt_q;
            end else begin
                fin_gt_d = dig_gt;
                fin_lt_d = dig_lt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            xs_q     <= '0;
            ys_q     <= '0;
            cnt_q    <= '0;
            dif_q    <= 1'b0;
            dif_gt_q <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            xgy_q    <= 1'b0;
            xsy_q    <= 1'b0;
            xey_q    <= 1'b0;
            steps_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        xs_q    <= x ^ msb_mask;
                        ys_q    <= y ^ msb_mask;
                        cnt_q   <= '0;
                        dif_q   <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (fin_d) begin
                        xgy_q   <= fin_gt_d;
                        xsy_q   <= fin_lt_d;
                        xey_q   <= !(fin_gt_d || fin_lt_d);
                        steps_q <= fin_steps_d;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        xs_q  <= xs_q << DIGIT;
                        ys_q  <= ys_q << DIGIT;
                        cnt_q <= cnt_q + CW'(1);
                        if (!dif_q && (dig_gt || dig_lt)) begin
                            dif_q    <= 1'b1;
                            dif_gt_q <= dig_gt;
                        end
                    end
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign xgy   = xgy_q;
    assign xsy   = xsy_q;
    assign xey   = xey_q;
    assign steps = steps_q;

endmodule

// File: tb/tb_seq_mag_cmp.sv
module tb_seq_mag_cmp;

    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CW    = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             is_signed;
    logic [WIDTH-1:0] x, y;
    logic             start1, start0;
    logic             ready1, done1, xgy1, xsy1, xey1;
    logic [CW-1:0]    steps1;
    logic             ready0, done0, xgy0, xsy0, xey0;
    logic [CW-1:0]    steps0;

    seq_mag_cmp #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .is_signed(is_signed), .x(x), .y(y),
        .ready(ready1), .done(done1), .xgy(xgy1), .xsy(xsy1), .xey(xey1), .steps(steps1)
    );

    seq_mag_cmp #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .is_signed(is_signed), .x(x), .y(y),
        .ready(ready0), .done(done0), .xgy(xgy0), .xsy(xsy0), .xey(xey0), .steps(steps0)
    );

    typedef struct {
        logic gt;
        logic lt;
        logic eq;
        int   steps;
        int   cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer compare for the flags; steps from the
    // position of the first differing MSB-first digit.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic s, input bit ee, input int acc);
        exp_t m;
        int va, vb, first, da, db;
        va    = s ? int'($signed(a)) : int'(a);
        vb    = s ? int'($signed(b)) : int'(b);
        first = NDIG;
        for (int i = 0; i < NDIG; i++) begin
            da = (int'(a) >> (WIDTH - DIGIT * (i + 1))) % (1 << DIGIT);
            db = (int'(b) >> (WIDTH - DIGIT * (i + 1))) % (1 << DIGIT);
            if (first == NDIG && da != db) first = i;
        end
        m.gt    = (va > vb);
        m.lt    = (va < vb);
        m.eq    = (va == vb);
        m.steps = ee ? ((first == NDIG) ? NDIG : first + 1) : NDIG;
        m.cyc   = acc + m.steps;
        return m;
    endfunction

    task automatic cmp_res(input string tag, input exp_t e, input logic gt, input logic lt,
                           input logic eq, input int st);
        chk({tag, "_xgy"}, gt, e.gt);
        chk({tag, "_xsy"}, lt, e.lt);
        chk({tag, "_xey"}, eq, e.eq);
        chk({tag, "_onehot"}, int'(gt) + int'(lt) + int'(eq), 1);
        chk({tag, "_steps"}, st, e.steps);
        chk({tag, "_latency_cycle"}, cyc, e.cyc);
    endtask

    exp_t e1, e0;
    logic prev_done1 = 1'b0;
    logic prev_done0 = 1'b0;

    always @(negedge clk) begin
        if (rst_n && done1) begin
            chk("dut1_done_width", prev_done1, 0);
            if (q1.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL dut1_unexpected_done actual=1 required=0 (t=%0t)", $time);
            end else begin
                e1 = q1.pop_front();
                cmp_res("dut1", e1, xgy1, xsy1, xey1, int'(steps1));
            end
        end
        prev_done1 <= done1;
    end

    always @(negedge clk) begin
        if (rst_n && done0) begin
            chk("dut0_done_width", prev_done0, 0);
            if (q0.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL dut0_unexpected_done actual=1 required=0 (t=%0t)", $time);
            end else begin
                e0 = q0.pop_front();
                cmp_res("dut0", e0, xgy0, xsy0, xey0, int'(steps0));
            end
        end
        prev_done0 <= done0;
    end

    // Called at a negedge while the selected DUT is idle; returns one negedge later.
    task automatic issue(input bit sel, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s);
        x         = a;
        y         = b;
        is_signed = s;
        if (sel) begin
            start1 = 1'b1;
            q1.push_back(model(a, b, s, 1'b1, cyc + 1));
        end else begin
            start0 = 1'b1;
            q0.push_back(model(a, b, s, 1'b0, cyc + 1));
        end
        @(negedge clk);
        start1 = 1'b0;
        start0 = 1'b0;
    endtask

    task automatic wait_ready(input bit sel);
        int n;
        n = 0;
        while (((sel ? ready1 : ready0) !== 1'b1) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) chk(sel ? "dut1_ready_timeout" : "dut0_ready_timeout", 0, 1);
    endtask

    task automatic wait_done1();
        int n;
        n = 0;
        while (done1 !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) chk("dut1_done_timeout", 0, 1);
    endtask

    function automatic logic [WIDTH-1:0] pick_b(input logic [WIDTH-1:0] a);
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return a;
        if (r == 1) return a ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
        return WIDTH'($urandom);
    endfunction

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rs;
        int               n;

        start1 = 1'b0;
        start0 = 1'b0;
        x = '0;
        y = '0;
        is_signed = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready1, 1);
        chk("rst_done", done1, 0);
        chk("rst_xgy", xgy1, 0);
        chk("rst_xsy", xsy1, 0);
        chk("rst_xey", xey1, 0);
        chk("rst_steps", int'(steps1), 0);
        chk("rst_ready_ee0", ready0, 1);
        chk("rst_steps_ee0", int'(steps0), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        wait_ready(1); issue(1, 8'h01, 8'h01, 1'b0);
        wait_ready(1); issue(1, 8'h80, 8'h7F, 1'b0);
        wait_ready(1); issue(1, 8'h80, 8'h7F, 1'b1);
        wait_ready(1); issue(1, 8'h03, 8'h02, 1'b0);
        wait_ready(0); issue(0, 8'h80, 8'h00, 1'b0);
        wait_ready(1); issue(1, 8'hFF, 8'hFE, 1'b1);
        wait_ready(1); issue(1, 8'h00, 8'hFF, 1'b1);

        // Start while busy is ignored; start in the done cycle is accepted
        wait_ready(1); issue(1, 8'h01, 8'h01, 1'b0);
        x = 8'hFF; y = 8'h00; is_signed = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("busy_ready", ready1, 0);
        wait_done1();
        chk("b2b_ready", ready1, 1);
        issue(1, 8'h10, 8'h20, 1'b0);

        // Reset during RUN aborts without a done pulse
        wait_ready(1); issue(1, 8'h01, 8'h02, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", ready1, 1);
        chk("abort_done", done1, 0);
        chk("abort_xgy", xgy1, 0);
        chk("abort_xsy", xsy1, 0);
        chk("abort_xey", xey1, 0);
        chk("abort_steps", int'(steps1), 0);
        q1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wait_ready(1); issue(1, 8'h5A, 8'h5B, 1'b1);

        // Random, early-exit instance; operands scrambled while running
        for (int i = 0; i < 10000; i++) begin
            wait_ready(1);
            ra = WIDTH'($urandom);
            rb = pick_b(ra);
            rs = 1'($urandom);
            issue(1, ra, rb, rs);
            x = WIDTH'($urandom);
            y = WIDTH'($urandom);
            is_signed = 1'($urandom);
        end

        // Random, constant-latency instance
        for (int i = 0; i < 300; i++) begin
            wait_ready(0);
            ra = WIDTH'($urandom);
            rb = pick_b(ra);
            rs = 1'($urandom);
            issue(0, ra, rb, rs);
            x = WIDTH'($urandom);
            y = WIDTH'($urandom);
        end

        n = 0;
        while ((q1.size() != 0 || q0.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q1.size() != 0 || q0.size() != 0) chk("drain_pending", q1.size() + q0.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
